updown_mod_counter: RTL and testbench
=====================================

// Module: updown_mod_counter
// PURPOSE
//  Parametrised up/down modulo counter with prescaler, parallel load and
//  terminal-count pulse. Generalises the fixed 4-bit free-running counter
//  used for pipeline timing and bring-up. It sits beside the core as a
//  timer and event-divider source.
// PARAMETERS
//  WIDTH      4   count register width in bits
//  MAX_COUNT  15  highest count value (modulus = MAX_COUNT+1); must be < 2**WIDTH
//  PRESCALE   1   enabled cycles per count step; must be >= 1 (1 = step every en cycle)
// PORTS
//  clk       in   1      sole clock; all logic on rising edge
//  reset     in   1      synchronous, active-low reset (0 = reset)
//  en        in   1      count enable; advances prescaler when high
//  up        in   1      direction: 1 = increment, 0 = decrement
//  load      in   1      parallel load strobe
//  load_val  in   WIDTH  value to load
//  count     out  WIDTH  current count (registered)
//  tc        out  1      terminal-count pulse (registered, 1 cycle)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low.
//  - Priority per edge: reset > load > en.
//  - Reset (reset==0 at posedge): count=0, tc=0, prescaler=0. A mid-operation
//    reset abandons any partial prescale; no tc is issued on that edge.
//  - Load: count <= (load_val > MAX_COUNT) ? MAX_COUNT : load_val; prescaler=0;
//    tc=0. The en input is ignored on a load edge.
//  - en=0 (no load): count and prescaler hold; tc=0.
//  - en=1: prescaler increments. When prescaler==PRESCALE-1, a step occurs
//    and the prescaler returns to 0. With PRESCALE=1, every en cycle steps.
//  - Step, up=1: count==MAX_COUNT -> count=0, tc=1; else count+1, tc=0.
//  - Step, down: count==0 -> count=MAX_COUNT, tc=1; else count-1, tc=0.
//  - up is sampled on the step edge only; toggling between steps is legal.
//  - tc is high in the same cycle that count shows the wrapped value, and
//    is low on every other cycle.
//  - Latency: a step or load is visible on count 1 cycle after the edge.
//  - Arithmetic is unsigned and modulo MAX_COUNT+1. Count never exceeds
//    MAX_COUNT. Prescaler width is $clog2(PRESCALE), minimum 1.
//  - Elaboration error if MAX_COUNT >= 2**WIDTH or PRESCALE < 1.
// CONFIGURATION
//  UDC_SATURATE_EN defined: no wrap. Up at MAX_COUNT holds MAX_COUNT; down
//    at 0 holds 0. tc=1 on every step attempted while at the bound.
//  UDC_SATURATE_EN undefined: modulo wrap exactly as in BEHAVIOUR.
//  Load, reset and prescaler behave identically in both builds.
// TESTING
//  1 Defaults: reset=0 for 2 clks, then en=1, up=1 for 20 clks
//    -> count 0..15,0,1,2,3; tc=1 only with count==0 after 15.
//  2 MAX_COUNT=9, up=0, start from 0 -> count 9,8,..; tc=1 with first 9;
//    after 10 steps count=9 again with tc=1.
//  3 PRESCALE=3, en=1, up=1 -> count steps every 3rd clk. Drop en for 5 clks
//    mid-prescale -> count and prescaler frozen; resume keeps phase.
//  4 Defaults, load=1 with load_val=7 while en=1 -> count=7 next cycle,
//    tc=0. MAX_COUNT=9, load_val=12 -> count=9 (clipped).
//  5 Assert reset=0 while count=5 and en=1 -> count=0, tc=0 next cycle.
//    Reset and load high together -> reset wins.
//  6 UDC_SATURATE_EN, defaults, up=1 from 14 -> 15,15,15 with tc=1 on each
//    held step. Then up=0 -> 14, tc=0.

Source files
------------

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down modulo counter with prescaler, parallel load and terminal-count pulse
//   clk       rising-edge clock
//   reset     synchronous active-low reset
//   en        count enable, advances the prescaler
//   up        direction, 1 = increment, 0 = decrement
//   load      parallel load strobe, clips load_val to MAX_COUNT
//   load_val  value to load
//   count     registered count
//   tc        registered one-cycle terminal-count pulse
//   UDC_SATURATE_EN defined: hold at the bound instead of wrapping
module updown_mod_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15,
  parameter int PRESCALE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
  if (MAX_COUNT >= 2 ** WIDTH || PRESCALE < 1) begin : g_bad_params
    $error("updown_mod_counter: need MAX_COUNT < 2**WIDTH and PRESCALE >= 1");
  end
  logic [WIDTH-1:0] count_d, count_q, stepped, wrapped;
  logic [PW-1:0] psc_d, psc_q;
  logic tc_d, tc_q, step, at_bound;
  always_comb begin
    step = en && psc_q == PLAST;
    at_bound = up ? count_q == MAXV : count_q == '0;
`ifdef UDC_SATURATE_EN
    wrapped = count_q;
`else
    wrapped = up ? '0 : MAXV;
`endif
    stepped = at_bound ? wrapped : up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    count_d = load ? (load_val > MAXV ? MAXV : load_val) : step ? stepped : count_q;
    psc_d = load ? '0 : !en ? psc_q : step ? '0 : psc_q + PW'(1);
    tc_d = !load && step && at_bound;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      psc_q <= '0;
      tc_q <= 1'b0;
    end else begin
      count_q <= count_d;
      psc_q <= psc_d;
      tc_q <= tc_d;
    end
  end
  assign count = count_q;
  assign tc = tc_q;
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: random and directed checks of two counter configurations against an arithmetic model
module tb_updown_mod_counter;
  logic clk = 1'b0;
  logic reset, en, up, load;
  logic [3:0] load_val;
  logic [3:0] count0, count1;
  logic tc0, tc1;
  int checks = 0;
  int errors = 0;
  int mc[2], mp[2], mt[2];
  int mm[2] = '{15, 9};
  int mps[2] = '{1, 3};
`ifdef UDC_SATURATE_EN
  bit sat = 1'b1;
`else
  bit sat = 1'b0;
`endif

  always #5 clk = ~clk;

  updown_mod_counter u_def (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count0), .tc(tc0)
  );

  updown_mod_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(3)) u_m9p3 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count1), .tc(tc1)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input int i);
    mt[i] = 0;
    if (!reset) begin
      mc[i] = 0;
      mp[i] = 0;
    end else if (load) begin
      mc[i] = int'(load_val) > mm[i] ? mm[i] : int'(load_val);
      mp[i] = 0;
    end else if (en) begin
      mp[i]++;
      if (mp[i] == mps[i]) begin
        mp[i] = 0;
        if (up) begin
          mt[i] = int'(mc[i] == mm[i]);
          mc[i] = (mt[i] && sat) ? mc[i] : (mc[i] + 1) % (mm[i] + 1);
        end else begin
          mt[i] = int'(mc[i] == 0);
          mc[i] = (mt[i] && sat) ? 0 : (mc[i] + mm[i]) % (mm[i] + 1);
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic u, input logic l, input logic [3:0] v);
    reset = r; en = e; up = u; load = l; load_val = v;
    @(posedge clk);
    model(0);
    model(1);
    #1;
    check("count_def", int'(count0), mc[0]);
    check("tc_def", int'(tc0), mt[0]);
    check("count_m9p3", int'(count1), mc[1]);
    check("tc_m9p3", int'(tc1), mt[1]);
  endtask

  initial begin
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 1, 5);
    for (int k = 0; k < 20; k++) cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 0, 1, 0, 0);
    for (int k = 0; k < 6; k++) cyc(1, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 36; k++) cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 7);
    cyc(1, 1, 1, 1, 12);
    cyc(1, 1, 1, 1, 14);
    for (int k = 0; k < 9; k++) cyc(1, 1, 1, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 5);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 1, 1, 9);
    for (int k = 0; k < 600; k++)
      cyc($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 19) == 0, 4'($urandom_range(0, 15)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
